regfile_wb_scheduler: RTL
=========================

// Module: regfile_wb_scheduler
// PURPOSE
//  Write-port scheduler and scoreboard for the core's 2R1W register file.
//  Shares the single synchronous write port among NUM_REQ writeback requesters
//  (ALU, load unit, ...) using round-robin arbitration.
//  Tracks pending destination registers and flags RAW/WAW hazards to issue logic.
//  Sits between the execute/memory writeback sources and the register file write port.
// PARAMETERS
//  REG_WIDTH       32  data width of one register
//  REG_ADDR_WIDTH  5   register select width; REG_COUNT = 2**REG_ADDR_WIDTH
//  NUM_REQ         2   number of writeback requesters (>=2)
//  R0_IS_ZERO      1   1: register 0 is hardwired zero (never busy, never written)
// PORTS
//  Clk_i        in   1                   clock (posedge)
//  Rst_i        in   1                   reset, asynchronous, active-high
//  Flush_i      in   1                   synchronous clear of all busy bits
//  Rsv_Valid_i  in   1                   issue stage reserves a destination
//  Rsv_Sel_i    in   REG_ADDR_WIDTH      register to reserve
//  Rsv_Ready_o  out  1                   reservation accepted this cycle
//  Chk_Ra_Sel_i in   REG_ADDR_WIDTH      source A to hazard-check
//  Chk_Rb_Sel_i in   REG_ADDR_WIDTH      source B to hazard-check
//  Hazard_o     out  1                   source A or B is busy (combinational)
//  Wb_Valid_i   in   NUM_REQ             per-requester writeback request
//  Wb_Ready_o   out  NUM_REQ             one-hot grant (combinational)
//  Wb_Sel_i     in   NUM_REQ*REG_ADDR_WIDTH  flattened destination; req i at [i*RAW +: RAW]
//  Wb_Data_i    in   NUM_REQ*REG_WIDTH   flattened write data; req i at [i*RW +: RW]
//  Rf_We_o      out  1                   to regfile Data_We_i (registered)
//  Rf_Rd_Sel_o  out  REG_ADDR_WIDTH      to regfile Rd_Sel_i (registered)
//  Rf_Data_o    out  REG_WIDTH           to regfile Data_i (registered)
//  Busy_o       out  REG_COUNT           scoreboard bits, debug/visibility
//  Wb_Err_o     out  1                   sticky: writeback to a non-busy register
// BEHAVIOUR
//  Reset (async): busy=0, rr pointer=NUM_REQ-1 (req 0 has first priority),
//   Rf_We_o=0, Rf_Rd_Sel_o=0, Rf_Data_o=0, Wb_Err_o=0.
//  Reserve: Rsv_Ready_o = Rsv_Valid_i & ~busy[Rsv_Sel_i] & ~Flush_i (no bypass of the
//   clear happening this edge). On handshake, busy[Rsv_Sel_i] is set at the next edge.
//   If R0_IS_ZERO and Rsv_Sel_i==0, the request is accepted and no bit is set.
//  Hazard_o = busy[Chk_Ra_Sel_i] | busy[Chk_Rb_Sel_i]; register 0 is never busy when
//   R0_IS_ZERO.
//  Arbitration: search starts at pointer+1 mod NUM_REQ; the first valid requester
//   gets Wb_Ready_o. At most one bit is high. On a grant, the pointer moves to the
//   granted index. Requesters hold Sel/Data stable until ready. Valid may not drop
//   before ready.
//  Write pipeline: on grant at edge T, Rf_We_o/Sel/Data are registered. The
//   regfile writes at edge T+1. busy[Sel] clears at edge T+1, when Rf_We_o=1,
//   so hazard drops when data lands. Total latency is 1 cycle to Rf_We_o and
//   2 edges to the committed value. Throughput is 1 write/cycle.
//  A grant with Sel==0 and R0_IS_ZERO is consumed with Rf_We_o=0.
//  Grant whose Sel is not busy: write still performed; Wb_Err_o set, cleared only by reset.
//  Flush_i: busy cleared at next edge (overrides set and clear); an Rf_We_o already
//   registered still writes the regfile.
//  Simultaneous set of reg X and clear of reg Y (X!=Y): both take effect. X==Y cannot
//   occur because X is busy, so Rsv_Ready_o=0.
//  No valid requesters: Rf_We_o=0 next cycle; Sel/Data hold their previous values.
// STRUCTURE
//  Shared header RegfileDefs.vh: REG_COUNT derivation, default widths, R0 constant.
//  Sub-module rr_arbiter #(N): valid vector in, one-hot grant out, pointer register
//   with advance-on-grant. The scoreboard and output stage stay in this module.
// TESTING
//  1. Reset mid-write (Rf_We_o=1, busy[5]=1), Rst_i pulsed asynchronously ->
//     all outputs 0 immediately, Busy_o=0.
//  2. Reserve x5, Chk_Ra_Sel_i=5 -> Hazard_o=1. Req0 writes x5=0xDEADBEEF ->
//     Rf_We_o=1 with Sel=5 next cycle. Hazard_o=0 the cycle after, and regfile x5
//     reads 0xDEADBEEF.
//  3. Both reqs valid for 4 cycles (x1..x4 reserved) -> grant sequence 0,1,0,1.
//     Rf_We_o stays high 4 consecutive cycles.
//  4. Reserve x7 while busy[7]=1 -> Rsv_Ready_o=0. Retry in the cycle Rf_We_o
//     writes x7 -> still 0. Next cycle -> 1.
//  5. R0_IS_ZERO=1: reserve x0 -> accepted and Busy_o unchanged. Writeback x0 ->
//     Wb_Ready_o=1 and Rf_We_o=0.
//  6. Writeback x9 with busy[9]=0 -> write happens and Wb_Err_o=1 sticky. Flush_i
//     with x3 busy -> Busy_o=0 next cycle.

Source files
------------

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared definitions for the register-file writeback scheduler.
//   - default parameter values for the scheduler and its arbiter
//   - register-count and index-width helpers
//   - index of the hardwired-zero register
package regfile_wb_scheduler_pkg;

    localparam int DEF_REG_WIDTH      = 32;
    localparam int DEF_REG_ADDR_WIDTH = 5;
    localparam int DEF_NUM_REQ        = 2;
    localparam int DEF_R0_IS_ZERO     = 1;

    // Register that reads as zero when R0_IS_ZERO is set.
    localparam int ZERO_REG = 0;

    // Number of architectural registers selectable by an address of this width.
    function automatic int reg_count(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Width of an index into n items; never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter for the shared register-file write port.
// The pointer holds the last granted index; the search for the next grant
// starts one past it, so a requester that just won has lowest priority.
// Ports:
//   clk          clock (posedge)
//   rst          asynchronous active-high reset; pointer -> N-1 (req 0 first)
//   valid_i      per-requester request
//   grant_o      one-hot grant (combinational)
//   grant_idx_o  index of the granted requester (valid with grant_vld_o)
//   grant_vld_o  any requester granted this cycle
module regfile_wb_scheduler_rr_arbiter
    import regfile_wb_scheduler_pkg::*;
#(
    parameter  int N  = DEF_NUM_REQ,
    localparam int IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  valid_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          grant_vld_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] grant_idx;
    logic          grant_vld;

    always_comb begin
        // NOTE: every variable gets a default before any conditional update,
        // otherwise the untaken path would hold its value and infer a latch.
        grant_vld = 1'b0;
        grant_idx = ptr_q;
        for (int off = 1; off <= N; off++) begin
            if (!grant_vld && valid_i[IW'((int'(ptr_q) + off) % N)]) begin
                grant_vld = 1'b1;
                grant_idx = IW'((int'(ptr_q) + off) % N);
            end
        end
    end

    always_comb begin
        grant_o = '0;
        if (grant_vld) begin
            grant_o[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = grant_vld ? grant_idx : ptr_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= IW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign grant_idx_o = grant_idx;
    assign grant_vld_o = grant_vld;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-port scheduler and scoreboard for a 2R1W register file.
// Shares the single write port among NUM_REQ writeback sources with round-robin
// arbitration, tracks destinations reserved by issue, and flags RAW/WAW hazards.
// Ports:
//   Clk_i, Rst_i        clock (posedge), asynchronous active-high reset
//   Flush_i             clear all busy bits at the next edge
//   Rsv_Valid_i/_Sel_i  issue reserves a destination register
//   Rsv_Ready_o         reservation accepted this cycle
//   Chk_Ra/Rb_Sel_i     sources to hazard-check; Hazard_o if either is busy
//   Wb_Valid_i          per-requester writeback request
//   Wb_Ready_o          one-hot grant (combinational)
//   Wb_Sel_i/Wb_Data_i  flattened per-requester destination and data
//   Rf_We_o/Rd_Sel_o/Data_o  registered register-file write port
//   Busy_o              scoreboard bits
//   Wb_Err_o            sticky: a writeback targeted a register that was not busy
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
#(
    parameter  int REG_WIDTH      = DEF_REG_WIDTH,
    parameter  int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter  int NUM_REQ        = DEF_NUM_REQ,
    parameter  int R0_IS_ZERO     = DEF_R0_IS_ZERO,
    localparam int REG_COUNT      = reg_count(REG_ADDR_WIDTH),
    localparam int REQ_IW         = idx_width(NUM_REQ)
) (
    input  logic                              Clk_i,
    input  logic                              Rst_i,
    input  logic                              Flush_i,
    input  logic                              Rsv_Valid_i,
    input  logic [REG_ADDR_WIDTH-1:0]         Rsv_Sel_i,
    output logic                              Rsv_Ready_o,
    input  logic [REG_ADDR_WIDTH-1:0]         Chk_Ra_Sel_i,
    input  logic [REG_ADDR_WIDTH-1:0]         Chk_Rb_Sel_i,
    output logic                              Hazard_o,
    input  logic [NUM_REQ-1:0]                Wb_Valid_i,
    output logic [NUM_REQ-1:0]                Wb_Ready_o,
    input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0] Wb_Sel_i,
    input  logic [NUM_REQ*REG_WIDTH-1:0]      Wb_Data_i,
    output logic                              Rf_We_o,
    output logic [REG_ADDR_WIDTH-1:0]         Rf_Rd_Sel_o,
    output logic [REG_WIDTH-1:0]              Rf_Data_o,
    output logic [REG_COUNT-1:0]              Busy_o,
    output logic                              Wb_Err_o
);

    localparam bit HAS_ZERO_REG = (R0_IS_ZERO != 0);

    logic [REG_COUNT-1:0]      busy_q, busy_d;
    logic                      rf_we_q, rf_we_d;
    logic [REG_ADDR_WIDTH-1:0] rf_sel_q, rf_sel_d;
    logic [REG_WIDTH-1:0]      rf_data_q, rf_data_d;
    logic                      wb_err_q, wb_err_d;

    logic [NUM_REQ-1:0]        grant;
    logic [REQ_IW-1:0]         grant_idx;
    logic                      grant_vld;

    logic [REG_ADDR_WIDTH-1:0] req_sel  [NUM_REQ];
    logic [REG_WIDTH-1:0]      req_data [NUM_REQ];
    logic [REG_ADDR_WIDTH-1:0] gnt_sel;
    logic [REG_WIDTH-1:0]      gnt_data;

    logic rsv_ready;
    logic rsv_is_zero;
    logic gnt_is_zero;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_sel[i]  = Wb_Sel_i[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        assign req_data[i] = Wb_Data_i[i*REG_WIDTH +: REG_WIDTH];
    end

    regfile_wb_scheduler_rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk         (Clk_i),
        .rst         (Rst_i),
        .valid_i     (Wb_Valid_i),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .grant_vld_o (grant_vld)
    );

    assign gnt_sel  = req_sel[grant_idx];
    assign gnt_data = req_data[grant_idx];

    // The zero register is never marked busy, so reserving or writing it is a
    // no-op that is still handshaked.
    assign rsv_is_zero = HAS_ZERO_REG && (Rsv_Sel_i == REG_ADDR_WIDTH'(ZERO_REG));
    assign gnt_is_zero = HAS_ZERO_REG && (gnt_sel == REG_ADDR_WIDTH'(ZERO_REG));

    // A flush this cycle blocks the reservation so it cannot survive the clear.
    assign rsv_ready = Rsv_Valid_i & ~busy_q[Rsv_Sel_i] & ~Flush_i;

    always_comb begin
        busy_d = busy_q;
        // Clear when the registered write reaches the regfile, so the hazard
        // drops in the same edge the data lands.
        if (rf_we_q) begin
            busy_d[rf_sel_q] = 1'b0;
        end
        if (rsv_ready && !rsv_is_zero) begin
            busy_d[Rsv_Sel_i] = 1'b1;
        end
        if (Flush_i) begin
            busy_d = '0;
        end
    end

    always_comb begin
        rf_we_d   = 1'b0;
        rf_sel_d  = rf_sel_q;
        rf_data_d = rf_data_q;
        wb_err_d  = wb_err_q;
        if (grant_vld) begin
            rf_sel_d  = gnt_sel;
            rf_data_d = gnt_data;
            rf_we_d   = !gnt_is_zero;
            // The write still goes through; the error only records it.
            if (!gnt_is_zero && !busy_q[gnt_sel]) begin
                wb_err_d = 1'b1;
            end
        end
    end

    // NOTE: busy_q is a flop vector rather than a RAM, so it can and must take
    // the asynchronous reset along with the rest of the state.
    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            busy_q    <= '0;
            rf_we_q   <= 1'b0;
            rf_sel_q  <= '0;
            rf_data_q <= '0;
            wb_err_q  <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            rf_we_q   <= rf_we_d;
            rf_sel_q  <= rf_sel_d;
            rf_data_q <= rf_data_d;
            wb_err_q  <= wb_err_d;
        end
    end

    assign Rsv_Ready_o = rsv_ready;
    assign Hazard_o    = busy_q[Chk_Ra_Sel_i] | busy_q[Chk_Rb_Sel_i];
    assign Wb_Ready_o  = grant;
    assign Rf_We_o     = rf_we_q;
    assign Rf_Rd_Sel_o = rf_sel_q;
    assign Rf_Data_o   = rf_data_q;
    assign Busy_o      = busy_q;
    assign Wb_Err_o    = wb_err_q;

endmodule
